// File: rtl/romarb_pkg.sv
// romarb_pkg: shared constants, types and helpers for the PRG/CHR ROM arbiter.
//   Channel ids, default word bases, address/data widths, arbiter state
//   encoding and the little-endian byte-lane selector.
package romarb_pkg;

  localparam int unsigned MEMAW_DEF = 22;
  localparam int unsigned ADDRW     = 21;
  localparam int unsigned TAGW      = 19;
  localparam int unsigned DATAW     = 32;
  localparam int unsigned BYTEW     = 8;

  // channel ids
  localparam logic ROMPRG = 1'b0;
  localparam logic ROMCHR = 1'b1;

  // default word addresses of PRG byte 0 and CHR byte 0 (CHR sits 2 MB above PRG)
  localparam logic [MEMAW_DEF-1:0] PRGBASE_DEF = 22'h000000;
  localparam logic [MEMAW_DEF-1:0] CHRBASE_DEF = 22'h080000;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  // pick byte lane l out of a little-endian word
  function automatic logic [BYTEW-1:0] lane_sel(input logic [DATAW-1:0] w,
                                                input logic [1:0]       l);
    logic [BYTEW-1:0] b;
    case (l)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/romarb_if.sv
// romarb_if: shared 32-bit external read port (SDRAM/BRAM bridge).
//   memaddr  word address          (master -> slave)
//   memreq   request level, held until memack
//   memack   one-cycle completion  (slave -> master)
//   memrdata read word, valid with memack
interface romarb_if #(
  parameter int unsigned MEMAW = 22
);
  logic [MEMAW-1:0]               memaddr;
  logic                           memreq;
  logic                           memack;
  logic [romarb_pkg::DATAW-1:0]   memrdata;

  modport master (output memaddr, output memreq, input memack, input memrdata);
  modport slave  (input memaddr, input memreq, output memack, output memrdata);
endinterface

// File: rtl/romarb_buf.sv
// romarb_buf: one-word read buffer for a single ROM channel.
//   addr      byte address being looked up
//   hit_c     buffered word matches addr[20:2] and is valid
//   rdata_c   byte lane addr[1:0] of the buffered word
//   ld/ld_*   load port: tag, word and the valid value to store
//   inval     clear valid (a simultaneous load decides valid itself)
module romarb_buf
  import romarb_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [ADDRW-1:0] addr,
  output logic             hit_c,
  output logic [BYTEW-1:0] rdata_c,
  input  logic             ld,
  input  logic [TAGW-1:0]  ld_tag,
  input  logic [DATAW-1:0] ld_data,
  input  logic             ld_valid,
  input  logic             inval
);

  logic [TAGW-1:0]  tag;
  logic [DATAW-1:0] data;
  logic             valid;

  // tag/data/valid storage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag   <= '0;
      data  <= '0;
      valid <= 1'b0;
    end else begin
      if (ld) begin
        tag   <= ld_tag;
        data  <= ld_data;
        valid <= ld_valid;
      end else if (inval) begin
        valid <= 1'b0;
      end
    end
  end

  assign hit_c   = valid && (tag == addr[ADDRW-1:2]);
  assign rdata_c = lane_sel(data, addr[1:0]);

endmodule

// File: rtl/romarb.sv
// romarb: serves mapper PRG/CHR ROM byte requests from one 32-bit memory port.
//   clk, reset            clock, async active-high reset
//   promaddr/promreq      PRG byte address / request level
//   promdata/promack      PRG byte / one-cycle completion
//   cromaddr/cromreq      CHR byte address / request level
//   cromdata/cromack      CHR byte / one-cycle completion
//   mem                   external word read port (romarb_if.master)
//   inval                 one-cycle pulse flushing both buffers
module romarb
  import romarb_pkg::*;
#(
  parameter int unsigned      MEMAW   = MEMAW_DEF,
  parameter logic [MEMAW-1:0] PRGBASE = MEMAW'(PRGBASE_DEF),
  parameter logic [MEMAW-1:0] CHRBASE = MEMAW'(CHRBASE_DEF)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [ADDRW-1:0] promaddr,
  input  logic             promreq,
  output logic [BYTEW-1:0] promdata,
  output logic             promack,
  input  logic [ADDRW-1:0] cromaddr,
  input  logic             cromreq,
  output logic [BYTEW-1:0] cromdata,
  output logic             cromack,
  romarb_if.master         mem,
  input  logic             inval
);

  logic             prom_req0, crom_req0;
  logic             prom_rise_c, crom_rise_c;
  logic             prom_hit_c, crom_hit_c;
  logic [BYTEW-1:0] prom_rd_c, crom_rd_c;

  logic             pend_prg, pend_chr;
  logic [TAGW-1:0]  word_prg, word_chr;
  logic [1:0]       lane_prg, lane_chr;

  arb_state_e       state;
  logic             gsel;
  logic             last_prg;
  logic             stale;
  logic [MEMAW-1:0] memaddr_q;
  logic             memreq_q;

  logic             done_c, ld_prg_c, ld_chr_c, ld_valid_c, grant_chr_c, grant_any_c;

  assign prom_rise_c = promreq && !prom_req0;
  assign crom_rise_c = cromreq && !crom_req0;

  assign done_c      = (state == ST_BUSY) && mem.memack;
  assign ld_prg_c    = done_c && (gsel == ROMPRG);
  assign ld_chr_c    = done_c && (gsel == ROMCHR);
  // a fetch overlapped by an invalidate still answers, but is not kept
  assign ld_valid_c  = !(stale || inval);

  // round-robin: CHR wins only if PRG is idle or PRG was granted last
  assign grant_chr_c = pend_chr && (!pend_prg || last_prg);
  assign grant_any_c = pend_prg || pend_chr;

  assign mem.memaddr = memaddr_q;
  assign mem.memreq  = memreq_q;

  romarb_buf u_prg_buf (
    .clk      (clk),
    .reset    (reset),
    .addr     (promaddr),
    .hit_c    (prom_hit_c),
    .rdata_c  (prom_rd_c),
    .ld       (ld_prg_c),
    .ld_tag   (word_prg),
    .ld_data  (mem.memrdata),
    .ld_valid (ld_valid_c),
    .inval    (inval)
  );

  romarb_buf u_chr_buf (
    .clk      (clk),
    .reset    (reset),
    .addr     (cromaddr),
    .hit_c    (crom_hit_c),
    .rdata_c  (crom_rd_c),
    .ld       (ld_chr_c),
    .ld_tag   (word_chr),
    .ld_data  (mem.memrdata),
    .ld_valid (ld_valid_c),
    .inval    (inval)
  );

  // edge detect, hit service, pending flags and the memory-port arbiter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prom_req0 <= 1'b0;
      crom_req0 <= 1'b0;
      promack   <= 1'b0;
      cromack   <= 1'b0;
      promdata  <= '0;
      cromdata  <= '0;
      pend_prg  <= 1'b0;
      pend_chr  <= 1'b0;
      word_prg  <= '0;
      word_chr  <= '0;
      lane_prg  <= '0;
      lane_chr  <= '0;
      state     <= ST_IDLE;
      gsel      <= ROMPRG;
      last_prg  <= 1'b0;
      stale     <= 1'b0;
      memaddr_q <= '0;
      memreq_q  <= 1'b0;
    end else begin
      prom_req0 <= promreq;
      crom_req0 <= cromreq;
      promack   <= 1'b0;
      cromack   <= 1'b0;

      if (prom_rise_c) begin
        if (prom_hit_c) begin
          promack  <= 1'b1;
          promdata <= prom_rd_c;
        end else begin
          pend_prg <= 1'b1;
          word_prg <= promaddr[ADDRW-1:2];
          lane_prg <= promaddr[1:0];
        end
      end

      if (crom_rise_c) begin
        if (crom_hit_c) begin
          cromack  <= 1'b1;
          cromdata <= crom_rd_c;
        end else begin
          pend_chr <= 1'b1;
          word_chr <= cromaddr[ADDRW-1:2];
          lane_chr <= cromaddr[1:0];
        end
      end

      case (state)
        ST_IDLE: begin
          stale <= 1'b0;
          if (grant_any_c) begin
            state    <= ST_BUSY;
            memreq_q <= 1'b1;
            gsel     <= grant_chr_c;
            last_prg <= !grant_chr_c;
            if (grant_chr_c) begin
              memaddr_q <= CHRBASE + MEMAW'(word_chr);
              pend_chr  <= 1'b0;
            end else begin
              memaddr_q <= PRGBASE + MEMAW'(word_prg);
              pend_prg  <= 1'b0;
            end
          end
        end
        ST_BUSY: begin
          if (inval) stale <= 1'b1;
          if (mem.memack) begin
            memreq_q <= 1'b0;
            state    <= ST_IDLE;
            if (gsel == ROMCHR) begin
              cromack  <= 1'b1;
              cromdata <= lane_sel(mem.memrdata, lane_chr);
            end else begin
              promack  <= 1'b1;
              promdata <= lane_sel(mem.memrdata, lane_prg);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_romarb.sv
// tb_romarb: directed bench for romarb with a scoreboard of expected bytes
// per channel and a fixed-latency memory responder.
module tb_romarb;

  localparam logic [21:0] PRGB = 22'h000000;
  localparam logic [21:0] CHRB = 22'h080000;
  localparam int          LAT  = 3;

  logic        clk;
  logic        reset;
  logic [20:0] promaddr, cromaddr;
  logic        promreq, cromreq, inval;
  logic [7:0]  promdata, cromdata;
  logic        promack, cromack;

  romarb_if #(.MEMAW(22)) mif ();

  romarb #(.MEMAW(22), .PRGBASE(PRGB), .CHRBASE(CHRB)) dut (
    .clk      (clk),
    .reset    (reset),
    .promaddr (promaddr),
    .promreq  (promreq),
    .promdata (promdata),
    .promack  (promack),
    .cromaddr (cromaddr),
    .cromreq  (cromreq),
    .cromdata (cromdata),
    .cromack  (cromack),
    .mem      (mif.master),
    .inval    (inval)
  );

  int          nchk = 0;
  int          nerr = 0;
  logic [7:0]  exp_prg[$];
  logic [7:0]  exp_crm[$];
  logic [21:0] grants[$];
  logic [21:0] lat_addr;
  int          cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // external ROM contents
  function automatic logic [31:0] rom_word(input logic [21:0] a);
    if (a == 22'h000001) return 32'hDDCCBBAA;
    if (a == 22'h080004) return 32'h44332211;
    return {a[7:0] ^ 8'hA5, a[7:0] ^ 8'h5A, a[7:0] + 8'h11, a[7:0] ^ 8'h3C};
  endfunction

  function automatic logic [7:0] exp_byte(input logic [21:0] base, input logic [20:0] a);
    logic [31:0] w;
    w = rom_word(base + 22'(a[20:2]));
    return w[8*a[1:0] +: 8];
  endfunction

  // memory responder: memack LAT cycles after memreq is first seen
  initial begin
    mif.memack   = 1'b0;
    mif.memrdata = '0;
    cnt          = 0;
    lat_addr     = '0;
    forever begin
      @(negedge clk);
      if (reset || !mif.memreq) begin
        cnt        = 0;
        mif.memack = 1'b0;
      end else begin
        cnt++;
        if (cnt == 1) begin
          lat_addr = mif.memaddr;
          grants.push_back(mif.memaddr);
        end else begin
          chk("memaddr_stable", 32'(mif.memaddr), 32'(lat_addr));
        end
        mif.memack   = (cnt == LAT + 1);
        mif.memrdata = rom_word(mif.memaddr);
      end
    end
  end

  // scoreboard: every ack must match one outstanding expected byte
  initial begin
    forever begin
      @(negedge clk);
      if (promack) begin
        chk("prg_outstanding", 32'(exp_prg.size()), 32'd1);
        if (exp_prg.size() != 0) chk("promdata", 32'(promdata), 32'(exp_prg.pop_front()));
      end
      if (cromack) begin
        chk("chr_outstanding", 32'(exp_crm.size()), 32'd1);
        if (exp_crm.size() != 0) chk("cromdata", 32'(cromdata), 32'(exp_crm.pop_front()));
      end
    end
  end

  task automatic req_prg(input logic [20:0] a, output int lat);
    @(negedge clk);
    promaddr = a;
    promreq  = 1'b1;
    exp_prg.push_back(exp_byte(PRGB, a));
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (promack) begin
        lat = k;
        break;
      end
    end
    promreq = 1'b0;
  endtask

  task automatic req_crm(input logic [20:0] a, output int lat);
    @(negedge clk);
    cromaddr = a;
    cromreq  = 1'b1;
    exp_crm.push_back(exp_byte(CHRB, a));
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (cromack) begin
        lat = k;
        break;
      end
    end
    cromreq = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    promreq = 1'b0;
    cromreq = 1'b0;
    inval   = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int lp, lc, n0;
    reset = 1'b1;
    promaddr = '0;
    cromaddr = '0;
    promreq  = 1'b0;
    cromreq  = 1'b0;
    inval    = 1'b0;
    repeat (2) @(negedge clk);

    // reset state
    chk("rst_promack", 32'(promack), 32'd0);
    chk("rst_cromack", 32'(cromack), 32'd0);
    chk("rst_memreq", 32'(mif.memreq), 32'd0);
    chk("rst_memaddr", 32'(mif.memaddr), 32'd0);
    chk("rst_promdata", 32'(promdata), 32'd0);
    chk("rst_cromdata", 32'(cromdata), 32'd0);
    reset = 1'b0;

    // PRG miss then a hit in the same word
    n0 = grants.size();
    req_prg(21'h000005, lp);
    chk("prg_miss_lat", 32'(lp), 32'd6);
    chk("prg_miss_reqs", 32'(grants.size() - n0), 32'd1);
    chk("prg_miss_addr", 32'(lat_addr), 32'h000001);
    n0 = grants.size();
    req_prg(21'h000007, lp);
    chk("prg_hit_lat", 32'(lp), 32'd1);
    chk("prg_hit_noreq", 32'(grants.size() - n0), 32'd0);

    // simultaneous misses after reset: PRG first, then CHR
    do_reset();
    grants.delete();
    fork
      req_prg(21'h000005, lp);
      req_crm(21'h000010, lc);
    join
    chk("tie_prg_lat", 32'(lp), 32'd6);
    chk("tie_chr_lat", 32'(lc), 32'd11);
    chk("tie_nreq", 32'(grants.size()), 32'd2);
    if (grants.size() == 2) begin
      chk("tie_first_addr", 32'(grants[0]), 32'h000001);
      chk("tie_second_addr", 32'(grants[1]), 32'h080004);
    end

    // CHR hit served while a PRG fetch is outstanding
    n0 = grants.size();
    fork
      req_prg(21'h000100, lp);
      begin
        repeat (3) @(negedge clk);
        req_crm(21'h000012, lc);
      end
    join
    chk("busy_prg_lat", 32'(lp), 32'd6);
    chk("busy_chr_hit_lat", 32'(lc), 32'd1);
    chk("busy_nreq", 32'(grants.size() - n0), 32'd1);
    chk("busy_addr", 32'(lat_addr), 32'h000040);

    // invalidate during an outstanding CHR fetch
    fork
      req_crm(21'h000020, lc);
      begin
        repeat (3) @(negedge clk);
        inval = 1'b1;
        @(negedge clk);
        inval = 1'b0;
      end
    join
    chk("inval_chr_lat", 32'(lc), 32'd6);
    chk("inval_chr_addr", 32'(lat_addr), 32'h080008);
    n0 = grants.size();
    req_crm(21'h000020, lc);
    chk("inval_chr_rehit_lat", 32'(lc), 32'd6);
    chk("inval_chr_rereq", 32'(grants.size() - n0), 32'd1);
    req_prg(21'h000100, lp);
    chk("inval_prg_flushed_lat", 32'(lp), 32'd6);

    // invalidate on the same edge as a hit: hit wins, buffer then empty
    fork
      req_prg(21'h000101, lp);
      begin
        @(negedge clk);
        inval = 1'b1;
        @(negedge clk);
        inval = 1'b0;
      end
    join
    chk("inval_hit_lat", 32'(lp), 32'd1);
    req_prg(21'h000101, lp);
    chk("inval_hit_after_lat", 32'(lp), 32'd6);

    // reset in the middle of a CHR fetch
    req_prg(21'h000005, lp);
    chk("pre_rst_miss_lat", 32'(lp), 32'd6);
    req_prg(21'h000006, lp);
    chk("pre_rst_hit_lat", 32'(lp), 32'd1);
    @(negedge clk);
    cromaddr = 21'h000030;
    cromreq  = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (mif.memreq) break;
    end
    chk("midbusy_memreq", 32'(mif.memreq), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_memreq", 32'(mif.memreq), 32'd0);
    chk("async_promack", 32'(promack), 32'd0);
    chk("async_cromack", 32'(cromack), 32'd0);
    chk("async_memaddr", 32'(mif.memaddr), 32'd0);
    cromreq = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    req_prg(21'h000006, lp);
    chk("post_rst_miss_lat", 32'(lp), 32'd6);
    chk("post_rst_addr", 32'(lat_addr), 32'h000001);

    repeat (4) @(negedge clk);
    chk("prg_queue_empty", 32'(exp_prg.size()), 32'd0);
    chk("chr_queue_empty", 32'(exp_crm.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
